pwm_array_core: RTL and testbench

//  Parametrised multi-channel PWM engine; successor to the fixed 3-channel, 32-bit PWM.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_timebase.sv | 77 +++++++
 rtl/pwm_array_core.sv | 122 ++++++++++++
 tb/tb_pwm_array_core.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM engine.
// Counting mode and timebase direction encodings.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and up / up-down counter for the PWM array.
// Flags the period boundary so the top can commit new settings.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  input  logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             boundary
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_cnt;
  logic             dir;

  // Prescaler terminal count gives one timebase tick.
  always_comb begin
    tick = enable && (pre_cnt == prescale);
  end

  // Boundary: last tick of the edge ramp, or the down-step to 0.
  always_comb begin
    boundary = 1'b0;
    if (tick && (period != '0)) begin
      if (mode == MODE_CENTER) begin
        boundary = (dir == DIR_DOWN) && (cnt == ONE);
      end else begin
        boundary = (cnt == period - ONE);
      end
    end
  end

  // Prescaler, counter and direction; idle parks everything at 0/up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
    end else if (!enable) begin
      pre_cnt <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
      if (period == '0) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (tick) begin
        if (mode == MODE_EDGE) begin
          cnt <= boundary ? '0 : cnt + ONE;
          dir <= DIR_UP;
        end else if (dir == DIR_UP) begin
          cnt <= cnt + ONE;
          if (cnt + ONE == period) begin
            dir <= DIR_DOWN;
          end
        end else begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            dir <= DIR_UP;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_array_core.sv
// Multi-channel PWM: shadowed config, boundary commit, comparators.
// Settings only take effect at a period boundary or while idle.
module pwm_array_core
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [PRE_W-1:0]        prescale_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    center_in,
  input  logic [NUM_CH-1:0]       polarity_in,
  input  logic                    update_req,
  output logic                    update_pend,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        cnt_value
);

  typedef struct packed {
    logic [CNT_W-1:0]        period;
    logic [PRE_W-1:0]        prescale;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic                    center;
    logic [NUM_CH-1:0]       pol;
  } cfg_t;

  cfg_t cfg_in;
  cfg_t shadow_q;
  cfg_t active_q;

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              boundary;
  logic              commit;
  logic [NUM_CH-1:0] raw;

  assign cfg_in = '{
    period:   period_in,
    prescale: prescale_in,
    duty:     duty_in,
    center:   center_in,
    pol:      polarity_in
  };

  assign commit    = boundary || !enable;
  assign cnt_value = cnt;

  pwm_timebase #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_tb (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .period   (active_q.period),
    .prescale (active_q.prescale),
    .mode     (active_q.center),
    .cnt      (cnt),
    .tick     (tick),
    .boundary (boundary)
  );

  // Shadow set follows the latest request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (update_req) begin
      shadow_q <= cfg_in;
    end
  end

  // Active set takes the shadow at a boundary or while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
    end else if (commit) begin
      active_q <= shadow_q;
    end
  end

  // A fresh capture outranks a simultaneous commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_pend <= 1'b0;
    end else if (update_req) begin
      update_pend <= 1'b1;
    end else if (commit) begin
      update_pend <= 1'b0;
    end
  end

  // Period pulse lines up with the wrap to cnt 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= tick && boundary;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
    assign raw[k] = cnt < active_q.duty[k*CNT_W +: CNT_W];
  end

  // Outputs sit at the inactive level when idle or period is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else if (!enable || (active_q.period == '0)) begin
      pwm_out <= active_q.pol;
    end else begin
      pwm_out <= raw ^ active_q.pol;
    end
  end

endmodule

// File: tb/tb_pwm_array_core.sv
// Bench for pwm_array_core: phase-based reference model,
// directed literal scenarios and randomized config traffic.
module tb_pwm_array_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period_in = '0;
  logic [15:0] prescale_in = '0;
  logic [95:0] duty_in = '0;
  logic        center_in = 1'b0;
  logic [2:0]  polarity_in = '0;
  logic        update_req = 1'b0;
  logic        update_pend;
  logic [2:0]  pwm_out;
  logic        period_tick;
  logic [31:0] cnt_value;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pwm_array_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .period_in   (period_in),
    .prescale_in (prescale_in),
    .duty_in     (duty_in),
    .center_in   (center_in),
    .polarity_in (polarity_in),
    .update_req  (update_req),
    .update_pend (update_pend),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt_value   (cnt_value)
  );

  typedef struct {
    longint per;
    longint pre;
    longint duty [3];
    bit     ctr;
    bit [2:0] pol;
  } mcfg_t;

  mcfg_t  m_sh;
  mcfg_t  m_act;
  bit     m_pend = 0;
  longint m_div = 0;
  longint m_ph = 0;
  bit [2:0] m_pwm = '0;
  bit     m_tick = 0;

  task automatic chk(string name, longint got, longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic mcfg_t zero_cfg();
    mcfg_t c;
    c.per = 0;
    c.pre = 0;
    for (int k = 0; k < 3; k++) c.duty[k] = 0;
    c.ctr = 0;
    c.pol = '0;
    return c;
  endfunction

  task automatic model_reset();
    m_sh = zero_cfg();
    m_act = zero_cfg();
    m_pend = 0;
    m_div = 0;
    m_ph = 0;
    m_pwm = '0;
    m_tick = 0;
  endtask

  // Position within the period -> count (triangle for centre).
  function automatic longint phase_cnt(longint ph, mcfg_t c);
    if (c.ctr && ph > c.per) return 2 * c.per - ph;
    return ph;
  endfunction

  task automatic model_step();
    longint n;
    longint len;
    longint c;
    bit tk;
    bit bnd;
    bit cm;
    mcfg_t nc;
    n = m_act.per;
    len = m_act.ctr ? 2 * n : n;
    c = phase_cnt(m_ph, m_act);
    tk = enable && (m_div == m_act.pre);
    bnd = tk && (n != 0) && (m_ph == len - 1);
    for (int k = 0; k < 3; k++) begin
      if (enable && n != 0)
        m_pwm[k] = (c < m_act.duty[k]) ^ m_act.pol[k];
      else
        m_pwm[k] = m_act.pol[k];
    end
    m_tick = bnd;
    m_div = (!enable || tk) ? 0 : m_div + 1;
    if (!enable || n == 0) m_ph = 0;
    else if (tk) m_ph = (m_ph + 1) % len;
    cm = !enable || bnd;
    if (cm) m_act = m_sh;
    if (update_req) begin
      nc.per = period_in;
      nc.pre = prescale_in;
      for (int k = 0; k < 3; k++) nc.duty[k] = duty_in[k*32 +: 32];
      nc.ctr = center_in;
      nc.pol = polarity_in;
      m_sh = nc;
      m_pend = 1;
    end else if (cm) begin
      m_pend = 0;
    end
  endtask

  initial model_reset();

  // Model advances on every edge; DUT compared 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (rst_n) begin
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_tick", period_tick, m_tick);
        chk("update_pend", update_pend, m_pend);
        chk("cnt_value", cnt_value, phase_cnt(m_ph, m_act));
      end
    end
  end

  task automatic set_cfg(int per, int pre, int d0, int d1, int d2,
                         bit ctr, bit [2:0] pol);
    period_in = 32'(per);
    prescale_in = 16'(pre);
    duty_in = {32'(d2), 32'(d1), 32'(d0)};
    center_in = ctr;
    polarity_in = pol;
  endtask

  task automatic pulse();
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_cnt(int val, int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cnt_value == 32'(val)) begin
        found = 1;
        break;
      end
    end
    chk("wait_cnt_reached", found, 1);
  endtask

  task automatic measure(int n, output int hi0, output int hi1,
                         output int hi2, output int ticks);
    hi0 = 0;
    hi1 = 0;
    hi2 = 0;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
      ticks += int'(period_tick);
    end
  endtask

  initial begin
    int h0, h1, h2, tk;
    idle(2);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pend", update_pend, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_cnt", cnt_value, 0);
    rst_n = 1'b1;
    idle(2);

    // Edge N=10, duty {3,0,10}: loaded while idle.
    set_cfg(10, 0, 3, 0, 10, 0, 3'b000);
    pulse();
    idle(2);
    enable = 1'b1;
    idle(15);
    measure(20, h0, h1, h2, tk);
    chk("edge_ch0_high", h0, 6);
    chk("edge_ch1_high", h1, 0);
    chk("edge_ch2_high", h2, 20);
    chk("edge_ticks", tk, 2);

    // Centre N=4, pre=1, duty0=2: committed at a running boundary.
    set_cfg(4, 1, 2, 0, 0, 1, 3'b000);
    pulse();
    idle(40);
    measure(32, h0, h1, h2, tk);
    chk("ctr_ch0_high", h0, 12);
    chk("ctr_ticks", tk, 2);

    // Edge N=10 duty 5, then two requests mid-period.
    set_cfg(10, 0, 5, 0, 0, 0, 3'b000);
    pulse();
    idle(30);
    wait_cnt(3, 40);
    set_cfg(8, 0, 2, 0, 0, 0, 3'b000);
    pulse();
    chk("req1_pend", update_pend, 1);
    idle(1);
    set_cfg(20, 0, 15, 0, 0, 0, 3'b000);
    pulse();
    idle(10);
    measure(40, h0, h1, h2, tk);
    chk("second_ch0_high", h0, 30);
    chk("second_ticks", tk, 2);

    // Request landing on the boundary cycle stays pending a period.
    wait_cnt(19, 50);
    set_cfg(20, 0, 10, 0, 0, 0, 3'b000);
    pulse();
    chk("bnd_pend", update_pend, 1);
    chk("bnd_tick", period_tick, 1);
    chk("bnd_cnt", cnt_value, 0);
    idle(19);
    chk("bnd_still_pend", update_pend, 1);
    idle(1);
    chk("bnd_pend_clear", update_pend, 0);

    // Polarity 101 while idle, then enable with duty0=2.
    enable = 1'b0;
    set_cfg(10, 0, 2, 0, 0, 0, 3'b101);
    pulse();
    idle(3);
    chk("idle_pol", pwm_out, 3'b101);
    enable = 1'b1;
    idle(1);
    chk("en_first", pwm_out, 3'b100);
    idle(1);
    chk("en_second", pwm_out, 3'b100);
    idle(1);
    chk("en_third", pwm_out, 3'b101);

    // Randomized config traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) begin
        set_cfg($urandom_range(0, 6), $urandom_range(0, 2),
                $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)));
        update_req = 1'b1;
      end else begin
        update_req = 1'b0;
      end
    end
    @(negedge clk);
    update_req = 1'b0;

    // Async reset mid-period with an N=0 config pending.
    enable = 1'b1;
    set_cfg(10, 0, 5, 5, 5, 0, 3'b000);
    pulse();
    idle(15);
    set_cfg(0, 0, 0, 0, 0, 0, 3'b111);
    pulse();
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_pend", update_pend, 0);
    chk("arst_cnt", cnt_value, 0);
    chk("arst_tick", period_tick, 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
